// File: rtl/edge_sync_pkg.sv
// Shared definitions for the multi-channel input conditioner.
// Edge-mode encodings and the direction qualification helper.
package edge_sync_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    function automatic logic edge_permits(input logic [1:0] mode, input logic rising);
        logic ok;
        ok = 1'b0;
        case (mode)
            EDGE_OFF:  ok = 1'b0;
            EDGE_RISE: ok = rising;
            EDGE_FALL: ok = !rising;
            EDGE_BOTH: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/edge_sync_ch.sv
// One conditioner channel: synchroniser chain, counter debounce, edge qualification,
// one-cycle event pulse, sticky flag and saturating event count.
module edge_sync_ch
    import edge_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_i,
    input  logic [1:0]       edge_mode,
    input  logic             evt_clr_i,
    output logic             level_o,
    output logic             pulse_o,
    output logic             evt_flag_o,
    output logic [CNT_W-1:0] evt_cnt_o
);

    localparam int                DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_TC  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
    logic                   level_q, level_d;
    logic                   level_dly_q;
    logic                   pulse_q, pulse_d;
    logic                   flag_q, flag_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // Plain flop chain; nothing may sit between the stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        if (sync == level_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_TC) begin
            level_d   = sync;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // The delayed level only feeds edge detection, so a mode change alone never pulses.
    assign pulse_d = (level_q != level_dly_q) && edge_permits(edge_mode, level_q);

    // A pulse wins over a clear issued in the same cycle.
    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (pulse_q) begin
            flag_d = 1'b1;
            if (evt_clr_i) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (evt_clr_i) begin
            flag_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q   <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            pulse_q     <= 1'b0;
            flag_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            deb_cnt_q   <= deb_cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            pulse_q     <= pulse_d;
            flag_q      <= flag_d;
            cnt_q       <= cnt_d;
        end
    end

    assign level_o    = level_q;
    assign pulse_o    = pulse_q;
    assign evt_flag_o = flag_q;
    assign evt_cnt_o  = cnt_q;

endmodule

// File: rtl/edge_sync_multi.sv
// Multi-channel input conditioner at the system-clock boundary.
// Replicates edge_sync_ch per channel and packs the per-channel results.
module edge_sync_multi
    import edge_sync_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       in_i,
    input  logic [2*CH-1:0]     edge_mode,
    input  logic [CH-1:0]       evt_clr_i,
    output logic [CH-1:0]       level_o,
    output logic [CH-1:0]       pulse_o,
    output logic [CH-1:0]       evt_flag_o,
    output logic [CH*CNT_W-1:0] evt_cnt_o
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_sync_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_i       (in_i[i]),
            .edge_mode  (edge_mode[2*i +: 2]),
            .evt_clr_i  (evt_clr_i[i]),
            .level_o    (level_o[i]),
            .pulse_o    (pulse_o[i]),
            .evt_flag_o (evt_flag_o[i]),
            .evt_cnt_o  (evt_cnt_o[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_edge_sync_multi.sv
// Directed bench for edge_sync_multi with a cycle-level reference model of each channel.
module tb_edge_sync_multi;

    localparam int CH   = 4;
    localparam int S    = 2;
    localparam int D    = 4;
    localparam int W    = 8;
    localparam int CMAX = (1 << W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     in_i = '1;
    logic [2*CH-1:0]   edge_mode = '0;
    logic [CH-1:0]     evt_clr_i = '0;
    logic [CH-1:0]     level_o, pulse_o, evt_flag_o;
    logic [CH*W-1:0]   evt_cnt_o;

    int checks = 0;
    int errors = 0;

    edge_sync_multi #(.CH(CH), .SYNC_STAGES(S), .DEB_CYCLES(D), .CNT_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_i       (in_i),
        .edge_mode  (edge_mode),
        .evt_clr_i  (evt_clr_i),
        .level_o    (level_o),
        .pulse_o    (pulse_o),
        .evt_flag_o (evt_flag_o),
        .evt_cnt_o  (evt_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int c);
        return int'(evt_cnt_o[c*W +: W]);
    endfunction

    function automatic bit permits(input int mode, input int rising);
        return (mode == 3) || (mode == 1 && rising != 0) || (mode == 2 && rising == 0);
    endfunction

    // Reference model: the synchronised stream is the raw input seen S edges late;
    // a new level is accepted once D consecutive synchronised samples disagree with it.
    int m_pipe [CH][S];
    int m_lvl  [CH];
    int m_run  [CH];
    int m_chg  [CH];
    int m_rise [CH];
    int m_pulse[CH];
    int m_flag [CH];
    int m_cnt  [CH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < S; k++) m_pipe[c][k] = 0;
                m_lvl[c] = 0; m_run[c] = 0; m_chg[c] = 0; m_rise[c] = 0;
                m_pulse[c] = 0; m_flag[c] = 0; m_cnt[c] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                int syncv;
                if (m_pulse[c] != 0) begin
                    m_flag[c] = 1;
                    if (evt_clr_i[c]) m_cnt[c] = 1;
                    else m_cnt[c] = (m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX;
                end else if (evt_clr_i[c]) begin
                    m_flag[c] = 0;
                    m_cnt[c]  = 0;
                end
                m_pulse[c] = (m_chg[c] != 0 && permits(int'(edge_mode[2*c +: 2]), m_rise[c])) ? 1 : 0;
                m_chg[c] = 0;
                syncv = m_pipe[c][S-1];
                m_run[c] = (syncv != m_lvl[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] == D) begin
                    m_lvl[c]  = syncv;
                    m_rise[c] = syncv;
                    m_chg[c]  = 1;
                    m_run[c]  = 0;
                end
                for (int k = S - 1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
                m_pipe[c][0] = in_i[c] ? 1 : 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                chk($sformatf("model_level%0d", c), int'(level_o[c]),    m_lvl[c]);
                chk($sformatf("model_pulse%0d", c), int'(pulse_o[c]),    m_pulse[c]);
                chk($sformatf("model_flag%0d", c),  int'(evt_flag_o[c]), m_flag[c]);
                chk($sformatf("model_cnt%0d", c),   cnt_of(c),           m_cnt[c]);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int c, input string name);
        int n;
        n = 0;
        while (!pulse_o[c] && n < 30) begin
            step();
            n++;
        end
        chk(name, int'(pulse_o[c]), 1);
    endtask

    initial begin
        // Reset held with all inputs high.
        step(3);
        chk("rst_level", int'(level_o), 0);
        chk("rst_pulse", int'(pulse_o), 0);
        chk("rst_flag",  int'(evt_flag_o), 0);
        chk("rst_cnt",   int'(evt_cnt_o), 0);
        in_i = '0;
        step();
        rst_n = 1'b1;
        edge_mode = 8'b00_10_11_01;
        step(3);

        // ch0 rise mode: latency of level and pulse.
        in_i[0] = 1'b1;
        step(5);
        chk("lat_level_e5", int'(level_o[0]), 0);
        step();
        chk("lat_level_e6", int'(level_o[0]), 1);
        chk("lat_pulse_e6", int'(pulse_o[0]), 0);
        step();
        chk("lat_pulse_e7", int'(pulse_o[0]), 1);
        step();
        chk("lat_pulse_e8", int'(pulse_o[0]), 0);
        chk("lat_flag0", int'(evt_flag_o[0]), 1);
        chk("lat_cnt0", cnt_of(0), 1);
        step(4);
        in_i[0] = 1'b0;
        step(10);
        chk("rise_only_cnt0", cnt_of(0), 1);

        // ch1 both mode: glitch rejected, real pulse gives two edges.
        in_i[1] = 1'b1;
        step(3);
        in_i[1] = 1'b0;
        step(10);
        chk("glitch_level1", int'(level_o[1]), 0);
        chk("glitch_cnt1", cnt_of(1), 0);
        in_i[1] = 1'b1;
        step(8);
        in_i[1] = 1'b0;
        step(10);
        chk("both_cnt1", cnt_of(1), 2);
        chk("both_flag1", int'(evt_flag_o[1]), 1);

        // ch2 fall mode, ch3 off.
        in_i[2] = 1'b1;
        in_i[3] = 1'b1;
        step(10);
        chk("fall_level2_hi", int'(level_o[2]), 1);
        chk("fall_cnt2_rise", cnt_of(2), 0);
        chk("off_level3_hi", int'(level_o[3]), 1);
        in_i[2] = 1'b0;
        in_i[3] = 1'b0;
        step(10);
        chk("fall_cnt2", cnt_of(2), 1);
        chk("off_level3_lo", int'(level_o[3]), 0);
        chk("off_cnt3", cnt_of(3), 0);
        chk("off_flag3", int'(evt_flag_o[3]), 0);

        // Mode change while stable must not pulse.
        edge_mode[5:4] = 2'b01;
        step(3);
        edge_mode[5:4] = 2'b11;
        step(3);
        edge_mode[5:4] = 2'b10;
        step(3);
        chk("modechg_cnt2", cnt_of(2), 1);

        // Clear coinciding with the pulse on ch0.
        in_i[0] = 1'b1;
        wait_pulse(0, "clr_pulse_seen");
        evt_clr_i[0] = 1'b1;
        step();
        evt_clr_i[0] = 1'b0;
        chk("clr_same_flag0", int'(evt_flag_o[0]), 1);
        chk("clr_same_cnt0", cnt_of(0), 1);
        in_i[0] = 1'b0;
        step(10);
        evt_clr_i[0] = 1'b1;
        step();
        evt_clr_i[0] = 1'b0;
        chk("clr_flag0", int'(evt_flag_o[0]), 0);
        chk("clr_cnt0", cnt_of(0), 0);

        // Saturation on ch1.
        evt_clr_i[1] = 1'b1;
        step();
        evt_clr_i[1] = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_i[1] = ~in_i[1];
            step(6);
        end
        step(6);
        chk("sat_cnt1", cnt_of(1), CMAX);
        for (int i = 0; i < 10; i++) begin
            in_i[1] = ~in_i[1];
            step(6);
        end
        step(6);
        chk("sat_hold_cnt1", cnt_of(1), CMAX);

        // Reset during a partial debounce on ch0.
        in_i[0] = 1'b1;
        step(4);
        rst_n = 1'b0;
        in_i[0] = 1'b0;
        step(2);
        chk("midrst_cnt1", cnt_of(1), 0);
        rst_n = 1'b1;
        step(10);
        chk("midrst_level0", int'(level_o[0]), 0);
        chk("midrst_cnt0", cnt_of(0), 0);
        chk("midrst_flag0", int'(evt_flag_o[0]), 0);

        // Input already high at reset release.
        in_i[0] = 1'b1;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(5);
        chk("rel_level_e5", int'(level_o[0]), 0);
        step();
        chk("rel_level_e6", int'(level_o[0]), 1);
        chk("rel_pulse_e6", int'(pulse_o[0]), 0);
        step();
        chk("rel_pulse_e7", int'(pulse_o[0]), 1);
        step();
        chk("rel_cnt0", cnt_of(0), 1);
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
